// File: rtl/skid_pipe_if.sv
// skid_pipe_if: upstream/downstream valid-ready handshake bundle for skid_pipe_reg
interface skid_pipe_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: two-entry skid pipeline register; SKID_PIPE_STALL_CNT_EN adds a saturating stall counter
module skid_pipe_reg #(parameter int WIDTH = 32) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
`ifdef SKID_PIPE_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    skid_pipe_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic in_ready_q, in_ready_d;
    logic in_fire, out_fire, main_en, skid_en;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            in_ready_q <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state_q <= state_d;
            in_ready_q <= in_ready_d;
            if (main_en) main_q <= main_d;
            if (skid_en) skid_q <= skid_d;
        end
    end
    always_comb begin
        in_fire = bus.in_valid & in_ready_q;
        out_fire = (state_q != EMPTY) & bus.out_ready;
        state_d = state_q;
        case (state_q)
            EMPTY: state_d = in_fire ? HALF : EMPTY;
            HALF: state_d = (in_fire & !out_fire) ? FULL : (!in_fire & out_fire) ? EMPTY : HALF;
            FULL: state_d = out_fire ? HALF : FULL;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = state_d != FULL;
        // FULL refills the head from the skid entry; other states load the head from upstream
        main_en = !flush & ((state_q == EMPTY & in_fire) | (state_q == HALF & in_fire & out_fire) | (state_q == FULL & out_fire));
        main_d = (state_q == FULL) ? skid_q : bus.in_data;
        skid_en = !flush & (state_q == HALF) & in_fire & !out_fire;
        skid_d = bus.in_data;
    end
    always_comb begin
        bus.out_valid = state_q != EMPTY;
        bus.in_ready = in_ready_q;
        bus.out_data = main_q;
    end
`ifdef SKID_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    always_comb begin
        stall_cnt_d = ((state_q != EMPTY) & !bus.out_ready & (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        stall_cnt = stall_cnt_q;
    end
`endif
endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb_skid_pipe_reg: table vectors, corner sequences and random traffic against a queue model
module tb_skid_pipe_reg;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    always #5 clk = ~clk;
    skid_pipe_if #(.WIDTH(32)) bus();
`ifdef SKID_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    skid_pipe_reg #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
`ifdef SKID_PIPE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .bus(bus)
    );
    int tests = 0, fails = 0;
    logic [31:0] q[$];
    logic [31:0] head_m = 0;
    int unsigned scnt_m = 0;
    bit last_fin;
    typedef struct {int r; int f; int iv; int d; int orr; int ov; int od; int ir;} vec_t;
    vec_t v[26];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask
    task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic orr);
        bit fout;
        rst = r;
        flush = f;
        bus.in_valid = iv;
        bus.in_data = d;
        bus.out_ready = orr;
        last_fin = iv && q.size() < 2;
        fout = q.size() > 0 && orr;
        if (r) scnt_m = 0;
        else if (q.size() > 0 && !orr && scnt_m < 65535) scnt_m++;
        if (r) begin
            q.delete();
            head_m = 0;
        end else if (f) q.delete();
        else begin
            if (fout) void'(q.pop_front());
            if (last_fin) q.push_back(d);
        end
        if (q.size() > 0) head_m = q[0];
        @(posedge clk);
        #1;
    endtask
    task automatic chk_model(input string n);
        chk({n, "_ov"}, {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
        chk({n, "_od"}, bus.out_data, head_m);
        chk({n, "_ir"}, {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
`ifdef SKID_PIPE_STALL_CNT_EN
        chk({n, "_cnt"}, {16'b0, stall_cnt}, scnt_m);
`endif
    endtask
    initial begin
        int acc;
        logic [31:0] held;
        v[0]  = '{1, 0, 1, 'h55, 0, 0, 0, 1};
        v[1]  = '{1, 0, 0, 0, 0, 0, 0, 1};
        v[2]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        v[3]  = '{0, 0, 1, 1, 1, 1, 1, 1};
        v[4]  = '{0, 0, 1, 2, 1, 1, 2, 1};
        v[5]  = '{0, 0, 1, 3, 1, 1, 3, 1};
        v[6]  = '{0, 0, 1, 4, 1, 1, 4, 1};
        v[7]  = '{0, 0, 0, 0, 1, 0, 4, 1};
        v[8]  = '{0, 0, 1, 'hA, 0, 1, 'hA, 1};
        v[9]  = '{0, 0, 1, 'hB, 0, 1, 'hA, 0};
        v[10] = '{0, 0, 1, 'hC, 0, 1, 'hA, 0};
        v[11] = '{0, 0, 0, 0, 1, 1, 'hB, 1};
        v[12] = '{0, 0, 0, 0, 1, 0, 'hB, 1};
        v[13] = '{0, 0, 1, 'h11, 0, 1, 'h11, 1};
        v[14] = '{0, 0, 1, 'h22, 0, 1, 'h11, 0};
        v[15] = '{0, 1, 1, 'h33, 0, 0, 'h11, 1};
        v[16] = '{0, 0, 0, 0, 1, 0, 'h11, 1};
        v[17] = '{0, 0, 1, 'h44, 1, 1, 'h44, 1};
        v[18] = '{0, 0, 0, 0, 1, 0, 'h44, 1};
        v[19] = '{0, 0, 1, 'h55, 0, 1, 'h55, 1};
        v[20] = '{0, 1, 0, 0, 1, 0, 'h55, 1};
        v[21] = '{0, 0, 1, 'h66, 0, 1, 'h66, 1};
        v[22] = '{0, 0, 1, 'h77, 0, 1, 'h66, 0};
        v[23] = '{1, 0, 1, 'h99, 1, 0, 0, 1};
        v[24] = '{0, 0, 1, 'h88, 1, 1, 'h88, 1};
        v[25] = '{0, 0, 0, 0, 1, 0, 'h88, 1};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 26; i++) begin
            step(v[i].r != 0, v[i].f != 0, v[i].iv != 0, 32'(v[i].d), v[i].orr != 0);
            chk($sformatf("vec%0d_ov", i), {31'b0, bus.out_valid}, 32'(v[i].ov));
            chk($sformatf("vec%0d_od", i), bus.out_data, 32'(v[i].od));
            chk($sformatf("vec%0d_ir", i), {31'b0, bus.in_ready}, 32'(v[i].ir));
        end
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 'hA5, 0);
        held = bus.out_data;
        chk("stall_head", held, 'hA5);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if ((i % 2 == 0) && bus.in_ready) acc++;
            step(0, 0, i % 2 == 0, 'h100 + i, 0);
            chk("stall_od", bus.out_data, held);
            chk("stall_ov", {31'b0, bus.out_valid}, 1);
        end
        chk("stall_accepted", acc, 1);
        step(0, 0, 0, 0, 1);
        chk("drain1", bus.out_data, 'h100);
        step(0, 0, 0, 0, 1);
        chk("drain_empty", {31'b0, bus.out_valid}, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1, $urandom, $urandom_range(2) != 0);
            chk_model("rnd");
        end
`ifdef SKID_PIPE_STALL_CNT_EN
        step(1, 0, 0, 0, 0);
        chk("cnt_reset", {16'b0, stall_cnt}, 0);
        step(0, 0, 1, 'h5A, 0);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0);
        chk("cnt_sat", {16'b0, stall_cnt}, 'hFFFF);
        step(0, 0, 0, 0, 0);
        chk("cnt_hold", {16'b0, stall_cnt}, 'hFFFF);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("cnt_flush", {16'b0, stall_cnt}, 'hFFFF);
        step(1, 0, 0, 0, 0);
        chk("cnt_rst", {16'b0, stall_cnt}, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
